imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes the instruction memory read by the single-cycle core's program counter. It accepts a framed stream of bytes over a valid/ready handshake, packs them MSB-first into 32-bit instruction words, and issues one write per word at consecutive word addresses. The core is held in clear (`cpu_hold`) until a frame passes its checksum.

## Interface
- `BASE_ADDR`, 8'h00: byte address of the first word written; must be a multiple of 4.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `MAX_WORDS`, 64: largest legal word count; 256-byte address space / 4.
- `clk` in 1: single clock; all state changes on its rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data` holds a byte.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `in_valid` and `in_ready` are both high.
- `reload` in 1: single-cycle pulse; leave DONE/ERR and await a new frame.
- `mem_wen` out 1: instruction memory write enable, one-cycle pulse.
- `mem_addr` out 8: byte address of the word being written.
- `mem_data` out 32: instruction word.
- `cpu_hold` out 1: drives the core's `clr`; high while no valid program is loaded.
- `done` out 1: frame loaded and checksum matched.
- `err` out 1: frame rejected.

## Operation
- Frame format: SYNC_BYTE, LEN (word count N), 4·N data bytes with each word MSB first, then CHK.
- CHK equals the 8-bit sum, modulo 256, of LEN and all data bytes. SYNC_BYTE is excluded from the sum.
- States and transitions:
  - IDLE: each accepted byte not equal to SYNC_BYTE is discarded. On SYNC_BYTE, go to LEN.
  - LEN: capture N and seed sum = N. If N > MAX_WORDS, go to ERR. If N = 0, go to SUM. Otherwise go to DATA.
  - DATA: shift each byte into the word register and add it to the sum. On the 4th byte of a word, schedule a write. After word N, go to SUM.
  - SUM: if the byte equals the sum, go to DONE; otherwise go to ERR.
  - DONE and ERR: sticky. `reload` returns to IDLE.
- Word k (0-based) is written to `BASE_ADDR + 4k`. The address arithmetic is 8-bit.
- With MAX_WORDS = 64 and BASE_ADDR = 0, the last address is 8'hFC and never wraps. A nonzero BASE_ADDR wraps modulo 256; this is permitted.
- `in_ready` = 1 in IDLE, LEN, DATA and SUM; 0 in DONE and ERR.
- `cpu_hold` = 0 only in DONE. `done` = 1 only in DONE. `err` = 1 only in ERR.
- A failed frame leaves the words already written in memory. `cpu_hold` stays high.
- `reload` has no effect in IDLE, LEN, DATA or SUM; a frame in progress is not aborted by it.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `mem_wen` = 0, `mem_addr` = `BASE_ADDR`, `mem_data` = 0, `cpu_hold` = 1, `done` = 0, `err` = 0.
- `mem_wen`, `mem_addr` and `mem_data` are registered outputs.
- Write latency: `mem_wen` pulses the cycle after the 4th byte of a word is accepted, for exactly 1 cycle.
- Streaming: a byte may be accepted in the same cycle as a pending write, so one byte per cycle is sustainable.
- After the CHK byte is accepted, `done` or `err` rises on the next cycle.
- When `done` rises, `cpu_hold` falls in that same cycle.
- The last data word's write pulse occurs no later than the cycle CHK is accepted. It therefore always precedes `cpu_hold` release.
- `reload` in DONE or ERR: IDLE on the next cycle. `cpu_hold` = 1 and `in_ready` = 1 from that cycle on.
- `clr` mid-frame: all state returns to reset values immediately. A partial word is discarded and no write is issued for it.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum {IDLE, LEN, DATA, SUM, DONE, ERR};
  - default constants SYNC_BYTE, MAX_WORDS and BASE_ADDR;
  - the instruction word width, 32.
- One sub-module, `word_packer`: 8→32-bit MSB-first shift register with a 2-bit byte counter. It pulses `word_valid` on the 4th byte and is cleared by `clr` or on frame start.
- The top level holds the FSM, the word counter, the checksum accumulator and the registered memory-write outputs.

## Test plan
- **Single word, back-to-back bytes.**
  - Stimulus: A5, 01, 20, 08, 00, 05, CHK = 8'h2E.
  - Required: one `mem_wen` with addr 00, data 32'h20080005; then `done` = 1, `cpu_hold` = 0, `in_ready` = 0.
- **Bad checksum.**
  - Stimulus: same frame with CHK = 8'h2F.
  - Required: the write still occurs; `err` = 1, `cpu_hold` = 1. After a `reload` pulse, the state is IDLE with `in_ready` = 1.
- **Over-length, with noise first.**
  - Stimulus: 00, FF, then A5, 41.
  - Required: noise bytes discarded with no write; `err` = 1 the cycle after LEN; no `mem_wen` ever.
- **Full 64-word load with random `in_valid` gaps.**
  - Required: writes at 00, 04, …, FC in order with matching data; `done` = 1.
- **Reset mid-word.**
  - Stimulus: assert `clr` after 2 data bytes of word 3, then send a new full 1-word frame.
  - Required: no write for the partial word; the new word is written at addr 00; `done` = 1.
- **Empty frame.**
  - Stimulus: A5, 00, 00.
  - Required: no writes; `done` = 1, `cpu_hold` = 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and default constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    SUM  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_WORDS_DEF = 64;
  localparam logic [7:0] BASE_ADDR_DEF = 8'h00;
  localparam int         WORD_W        = 32;

  // Byte address of word idx; 8-bit arithmetic wraps modulo 256 on purpose.
  function automatic logic [7:0] word_addr(input logic [7:0] base, input logic [5:0] idx);
    return base + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// 8->32 bit MSB-first packer; word_valid/word are combinational on the 4th byte so the
// top level can register the memory write in the same edge that accepts that byte.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  cnt_r;
  logic [23:0] shift_r;

  // Byte position counter and the three older bytes of the word in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (start) begin
      cnt_r   <= 2'd0;
      shift_r <= 24'd0;
    end else if (byte_valid) begin
      cnt_r   <= cnt_r + 2'd1;
      shift_r <= {shift_r[15:0], byte_data};
    end else begin
      cnt_r   <= cnt_r;
      shift_r <= shift_r;
    end
  end

  assign word_valid = byte_valid && (cnt_r == 2'd3);
  assign word       = {shift_r, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: checks SYNC/LEN/DATA/CHK frames, writes packed
// words to instruction memory and holds the core in clear until a frame verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_wen,
  output logic [7:0]        mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                accept_s;
  logic                frame_start_s;
  logic                pack_valid_s;
  logic                word_valid_s;
  logic                last_word_s;
  logic [WORD_W-1:0]   word_s;
  logic [7:0]          len_r;
  logic [7:0]          sum_r;
  logic [6:0]          word_cnt_r;

  assign accept_s      = in_valid && in_ready;
  assign pack_valid_s  = accept_s && (state_r == DATA);
  assign frame_start_s = accept_s && (state_r == IDLE) && (in_data == SYNC_BYTE);
  assign last_word_s   = (({1'b0, word_cnt_r}) + 8'd1) == len_r;

  word_packer u_packer (
    .clk        (clk),
    .clr        (clr),
    .start      (frame_start_s),
    .byte_valid (pack_valid_s),
    .byte_data  (in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Frame sequencing; reload is honoured only in the sticky DONE/ERR states.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start_s) state_nxt_s = LEN;
        else               state_nxt_s = IDLE;
      end
      LEN: begin
        if (!accept_s)               state_nxt_s = LEN;
        else if (in_data > MAX_LEN)  state_nxt_s = ERR;
        else if (in_data == 8'd0)    state_nxt_s = SUM;
        else                         state_nxt_s = DATA;
      end
      DATA: begin
        if (word_valid_s && last_word_s) state_nxt_s = SUM;
        else                             state_nxt_s = DATA;
      end
      SUM: begin
        if (!accept_s)              state_nxt_s = SUM;
        else if (in_data == sum_r)  state_nxt_s = DONE;
        else                        state_nxt_s = ERR;
      end
      DONE, ERR: begin
        if (reload) state_nxt_s = IDLE;
        else        state_nxt_s = state_r;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, counters, checksum and all registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r    <= IDLE;
      len_r      <= 8'd0;
      sum_r      <= 8'd0;
      word_cnt_r <= 7'd0;
      in_ready   <= 1'b1;
      mem_wen    <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_data   <= {WORD_W{1'b0}};
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      in_ready <= (state_nxt_s != DONE) && (state_nxt_s != ERR);
      cpu_hold <= (state_nxt_s != DONE);
      done     <= (state_nxt_s == DONE);
      err      <= (state_nxt_s == ERR);
      mem_wen  <= word_valid_s;

      if (word_valid_s) begin
        mem_addr <= word_addr(BASE_ADDR, word_cnt_r[5:0]);
        mem_data <= word_s;
      end else begin
        mem_addr <= mem_addr;
        mem_data <= mem_data;
      end

      if (accept_s && (state_r == LEN)) begin
        len_r      <= in_data;
        sum_r      <= in_data;
        word_cnt_r <= 7'd0;
      end else if (pack_valid_s) begin
        len_r      <= len_r;
        sum_r      <= sum_r + in_data;
        word_cnt_r <= word_valid_s ? word_cnt_r + 7'd1 : word_cnt_r;
      end else begin
        len_r      <= len_r;
        sum_r      <= sum_r;
        word_cnt_r <= word_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from the framing
// rules, expected writes are queued at issue time and a monitor checks each mem_wen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          gaps_en = 1'b0;
  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] frame_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
      end else begin
        check("write_addr", {24'd0, mem_addr}, {24'd0, exp_addr_q.pop_front()});
        check("write_data", mem_data, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int tries;
    @(negedge clk);
    if (gaps_en) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (in_ready !== 1'b1 && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends the first n_words of frame_words and queues their expected writes; returns the running sum.
  task automatic send_words(input int n_words, input logic [7:0] seed, output logic [7:0] sum);
    logic [7:0] b;
    sum = seed;
    for (int k = 0; k < n_words; k++) begin
      exp_addr_q.push_back(8'(4 * k));
      exp_data_q.push_back(frame_words[k]);
      for (int j = 3; j >= 0; j--) begin
        b = frame_words[k][8*j +: 8];
        sum = sum + b;
        send_byte(b);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] n, input bit bad_chk, input bit pulse_reload);
    logic [7:0] sum;
    send_byte(8'hA5);
    reload = pulse_reload;
    send_byte(n);
    reload = 1'b0;
    if (n > 8'd64) begin
      end_stream();
    end else begin
      send_words(int'(n), n, sum);
      send_byte(bad_chk ? sum + 8'd1 : sum);
      end_stream();
    end
  endtask

  task automatic check_outcome(input string name, input bit exp_done);
    check({name, "_done"},     {31'd0, done},     {31'd0, exp_done});
    check({name, "_err"},      {31'd0, err},      {31'd0, !exp_done});
    check({name, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({name, "_writes_left"}, exp_addr_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({name, "_done"},     {31'd0, done},     32'd0);
    check({name, "_err"},      {31'd0, err},      32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check_idle(name);
    check({name, "_mem_wen"},  {31'd0, mem_wen},  32'd0);
    check({name, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
    check({name, "_mem_data"}, mem_data,          32'd0);
  endtask

  task automatic do_reload(input string name);
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_idle(name);
  endtask

  task automatic fill_words(input int n);
    frame_words.delete();
    for (int k = 0; k < n; k++) frame_words.push_back($urandom());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] sum;
    logic [7:0] n;
    logic [7:0] nb;
    bit         bad;
    clr = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    reload = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    clr = 1'b0;

    frame_words.delete();
    frame_words.push_back(32'h20080005);
    send_frame(8'd1, 1'b0, 1'b0);
    check_outcome("single_word", 1'b1);
    do_reload("single_reload");

    send_frame(8'd1, 1'b1, 1'b0);
    check_outcome("bad_chk", 1'b0);
    do_reload("bad_chk_reload");

    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h41, 1'b0, 1'b0);
    check_outcome("over_len", 1'b0);
    do_reload("over_len_reload");

    gaps_en = 1'b1;
    fill_words(64);
    send_frame(8'd64, 1'b0, 1'b0);
    check_outcome("full_load", 1'b1);
    gaps_en = 1'b0;
    do_reload("full_load_reload");

    fill_words(4);
    send_byte(8'hA5);
    send_byte(8'd4);
    send_words(3, 8'd4, sum);
    send_byte(frame_words[3][31:24]);
    send_byte(frame_words[3][23:16]);
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    check("mid_reset_writes_left", exp_addr_q.size(), 32'd0);
    clr = 1'b0;
    fill_words(1);
    send_frame(8'd1, 1'b0, 1'b0);
    check_outcome("after_reset", 1'b1);
    do_reload("after_reset_reload");

    send_frame(8'd0, 1'b0, 1'b0);
    check_outcome("empty", 1'b1);
    do_reload("empty_reload");

    for (int f = 0; f < 8; f++) begin
      gaps_en = ($urandom_range(0, 1) == 1);
      n = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(65, 255)) : 8'($urandom_range(0, 12));
      bad = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
      end
      fill_words((n > 8'd64) ? 0 : int'(n));
      send_frame(n, bad, ($urandom_range(0, 1) == 1));
      check_outcome("random_frame", (n <= 8'd64) && !bad);
      do_reload("random_reload");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
